// File: rtl/toast_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply and restoring divide run on magnitudes; signs are fixed up after the loop.
module toast_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rdOut;
  logic              r_negA;
  logic              r_negR;
  logic              r_done;
  logic              r_busy;

  logic              w_accept;
  logic              w_op1Signed;
  logic              w_op2Signed;
  logic              w_neg1;
  logic              w_neg2;
  logic              w_divZero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [XLEN-1:0]   w_specQuot;
  logic [XLEN-1:0]   w_specRem;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_mulNext;
  logic [2*XLEN-1:0] w_divNext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixRes;

  // start_i is ignored while done_o is high: the finished instruction is still sitting in EX.
  assign w_accept    = start_i & (r_state == S_IDLE) & ~r_done & ~flush_i;
  assign w_op1Signed = (op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110);
  assign w_op2Signed = (op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110);
  assign w_neg1      = w_op1Signed & op1_i[XLEN-1];
  assign w_neg2      = w_op2Signed & op2_i[XLEN-1];
  assign w_abs1      = w_neg1 ? -op1_i : op1_i;
  assign w_abs2      = w_neg2 ? -op2_i : op2_i;
  assign w_divZero   = op_i[2] & (op2_i == '0);
  assign w_ovf       = op_i[2] & ~op_i[0] & (op1_i == MIN_NEG) & (op2_i == '1);
  assign w_specQuot  = w_divZero ? '1 : MIN_NEG;
  assign w_specRem   = w_divZero ? op1_i : '0;

  assign w_addend  = r_acc[0] ? r_opnd : '0;
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};
  // Divide keeps {remainder, dividend/quotient} in one register; quotient bits enter at the LSB.
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
  assign w_divNext = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod   = r_negA ? -r_acc : r_acc;
  assign w_quot   = r_negA ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem    = r_negR ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fixRes = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                            : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  assign stall_o   = ~flush_i & ((start_i & (r_state == S_IDLE) & ~r_done) | (r_state != S_IDLE));
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign result_o  = r_result;
  assign rd_addr_o = r_rdOut;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_rdOut  <= '0;
      r_negA   <= 1'b0;
      r_negR   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush_i && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_op   <= op_i;
              r_rd   <= rd_addr_i;
              r_opnd <= w_abs2;
              r_cnt  <= '0;
              r_busy <= 1'b1;
              // Divide-by-zero and signed overflow have fixed answers, so the loop is skipped.
              if (w_divZero || w_ovf) begin
                r_acc   <= {w_specRem, w_specQuot};
                r_negA  <= 1'b0;
                r_negR  <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_acc   <= {{XLEN{1'b0}}, w_abs1};
                r_negA  <= w_neg1 ^ w_neg2;
                r_negR  <= w_neg1;
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_acc <= r_op[2] ? w_divNext : w_mulNext;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(XLEN - 1)) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_acc   <= {r_acc[2*XLEN-1:XLEN], w_fixRes};
            r_state <= S_DONE;
          end
          S_DONE: begin
            r_result <= r_acc[XLEN-1:0];
            r_rdOut  <= r_rd;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toast_muldiv_unit.sv
// Self-checking bench for toast_muldiv_unit: a cycle-level reference model built from plain
// 64-bit arithmetic and operation latencies, directed RV32M corner cases, and random operations.
module tb_toast_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int errors = 0;
  int checks = 0;

  int          mLeft   = 0;
  bit          mDone   = 1'b0;
  bit          wasDone = 1'b0;
  logic [31:0] mRes    = '0;
  logic [31:0] pendRes = '0;
  logic [4:0]  mRd     = '0;
  logic [4:0]  pendRd  = '0;

  toast_muldiv_unit #(.XLEN(32)) dut (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .flush_i   (flush_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .rd_addr_i (rd_addr_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  // Free-running 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with wide arithmetic.
  function automatic logic [31:0] refOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    int              qa;
    int              qb;
    logic [31:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    qa = $signed(a);
    qb = $signed(b);
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = longint'(sa * sb); r = p[63:32]; end
      3'd2: begin p = longint'(sa * longint'(ub)); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = 32'(qa / qb);
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else r = 32'(qa % qb);
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Reference model: an accepted op finishes 34 edges later (2 for special divides) unless flushed.
  initial forever begin
    @(posedge clk_i or negedge resetn_i);
    if (!resetn_i) begin
      mLeft = 0;
      mDone = 1'b0;
      mRes  = '0;
      mRd   = '0;
    end else begin
      wasDone = mDone;
      mDone   = 1'b0;
      if (mLeft > 0) begin
        if (flush_i) begin
          mLeft = 0;
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            mDone = 1'b1;
            mRes  = pendRes;
            mRd   = pendRd;
          end
        end
      end else if (start_i && !wasDone && !flush_i) begin
        pendRes = refOp(op_i, op1_i, op2_i);
        pendRd  = rd_addr_i;
        mLeft   = isSpecial(op_i, op1_i, op2_i) ? 2 : 34;
      end
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge.
  initial forever begin
    @(negedge clk_i);
    checkOutput("busy", {31'b0, busy_o}, {31'b0, (mLeft > 0)});
    checkOutput("done", {31'b0, done_o}, {31'b0, mDone});
    checkOutput("stall", {31'b0, stall_o},
                {31'b0, !flush_i && ((start_i && mLeft == 0 && !mDone) || mLeft > 0)});
    checkOutput("result", result_o, mRes);
    checkOutput("rd", {27'b0, rd_addr_o}, {27'b0, mRd});
  end

  // Drives one operation (entered at edge+2) and checks latency, stall span and result.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int flushAt, input string name,
                               input bit hasLit, input logic [31:0] lit);
    int          n;
    int          stallCnt;
    bit          seen;
    bit          special;
    logic [31:0] exp;
    logic [31:0] prevRes;
    logic [4:0]  prevRd;
    exp      = refOp(op, a, b);
    special  = isSpecial(op, a, b);
    if (hasLit) checkOutput({name, " model"}, exp, lit);
    prevRes  = result_o;
    prevRd   = rd_addr_o;
    op_i     = op;
    op1_i    = a;
    op2_i    = b;
    rd_addr_i = rd;
    start_i  = 1'b1;
    n        = 0;
    stallCnt = 0;
    seen     = 1'b0;
    if (flushAt > 0) begin
      while (n < flushAt) begin
        @(posedge clk_i); n++; #2;
      end
      flush_i = 1'b1;
      start_i = 1'b0;
      #1;
      checkOutput({name, " flush stall"}, {31'b0, stall_o}, 32'h0);
      @(posedge clk_i); #2;
      flush_i = 1'b0;
      checkOutput({name, " flush busy"}, {31'b0, busy_o}, 32'h0);
      checkOutput({name, " flush result"}, result_o, prevRes);
      checkOutput({name, " flush rd"}, {27'b0, rd_addr_o}, {27'b0, prevRd});
      repeat (36) begin
        @(posedge clk_i); #2;
        if (done_o) seen = 1'b1;
      end
      checkOutput({name, " no done after flush"}, {31'b0, seen}, 32'h0);
    end else begin
      while (n < 60 && !seen) begin
        @(posedge clk_i); n++; #2;
        if (done_o) seen = 1'b1;
        else if (stall_o) stallCnt++;
      end
      checkOutput({name, " done seen"}, {31'b0, seen}, 32'h1);
      checkOutput({name, " latency"}, 32'(n), special ? 32'd3 : 32'd35);
      checkOutput({name, " stall cycles"}, 32'(stallCnt), special ? 32'd2 : 32'd34);
      checkOutput({name, " stall in done"}, {31'b0, stall_o}, 32'h0);
      checkOutput({name, " value"}, result_o, exp);
      checkOutput({name, " rd tag"}, {27'b0, rd_addr_o}, {27'b0, rd});
      if (hasLit) checkOutput({name, " literal"}, result_o, lit);
      // start_i stays high through the done cycle; it must not relaunch the op.
      @(posedge clk_i); #2;
      start_i = 1'b0;
      checkOutput({name, " no relaunch"}, {31'b0, busy_o}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    int          fa;
    resetn_i  = 1'b0;
    flush_i   = 1'b0;
    start_i   = 1'b0;
    op_i      = '0;
    op1_i     = '0;
    op2_i     = '0;
    rd_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    checkOutput("reset result", result_o, 32'h0);
    checkOutput("reset done", {31'b0, done_o}, 32'h0);
    resetn_i = 1'b1;
    @(posedge clk_i); #2;

    applyStimulus(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd1, 0, "MUL 7x-3", 1'b1, 32'hFFFFFFEB);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd2, 0, "MULH", 1'b1, 32'h40000000);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0, "MULHU", 1'b1, 32'hFFFFFFFE);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0, "MULHSU", 1'b1, 32'hFFFFFFFF);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd5, 0, "DIV -7/2", 1'b1, 32'hFFFFFFFD);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6, 0, "REM -7/2", 1'b1, 32'hFFFFFFFF);
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd7, 0, "DIVU 100/7", 1'b1, 32'd14);
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd8, 0, "REMU 100/7", 1'b1, 32'd2);
    applyStimulus(3'd4, 32'd5, 32'd0, 5'd9, 0, "DIV 5/0", 1'b1, 32'hFFFFFFFF);
    applyStimulus(3'd6, 32'd5, 32'd0, 5'd10, 0, "REM 5/0", 1'b1, 32'd5);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0, "DIV ovf", 1'b1, 32'h80000000);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 0, "REM ovf", 1'b1, 32'h0);

    applyStimulus(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd13, 11, "flush iter10", 1'b0, 32'h0);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'h00000002, 5'd14, 0, "MULHU after flush", 1'b1, 32'h1);

    // Asynchronous reset between edges in the middle of a multiply.
    op_i = 3'd0; op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd15; start_i = 1'b1;
    repeat (15) @(posedge clk_i);
    #3;
    resetn_i = 1'b0;
    start_i  = 1'b0;
    #1;
    checkOutput("async reset busy", {31'b0, busy_o}, 32'h0);
    checkOutput("async reset stall", {31'b0, stall_o}, 32'h0);
    checkOutput("async reset result", result_o, 32'h0);
    checkOutput("async reset rd", {27'b0, rd_addr_o}, 32'h0);
    @(posedge clk_i); #2;
    resetn_i = 1'b1;
    @(posedge clk_i); #2;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'h0;
        2: ra = 32'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'h1;
        3: rb = 32'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      fa = 0;
      if (!isSpecial(rop, ra, rb) && $urandom_range(0, 7) == 0) fa = $urandom_range(1, 34);
      applyStimulus(rop, ra, rb, 5'($urandom_range(0, 31)), fa, "random op", 1'b0, 32'h0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk_i); #2;
      end
    end

    repeat (3) @(posedge clk_i);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toast_muldiv_unit.md
Name: toast_muldiv_unit

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
- Accepts one M-extension operation from EX and holds the pipeline through stall_o while it runs a shift-add or restoring-division loop.
- Returns a 32-bit result with a one-cycle done_o pulse; EX muxes that result into its ALU result register.
- Aborts cleanly on pipeline flush.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN)+1.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; aborts any operation in progress
- start_i  in  1  M-op present in EX with operands forwarding-resolved
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  in  XLEN  rs1 operand
- op2_i  in  XLEN  rs2 operand
- rd_addr_i  in  5  destination register tag
- stall_o  out  1  hold IF/ID/EX; combinational
- busy_o  out  1  state != IDLE; registered
- done_o  out  1  one-cycle result-valid pulse; registered
- result_o  out  XLEN  result; holds until next done_o
- rd_addr_o  out  5  tag latched at start

Behaviour:
- Reset: asynchronous, active-low. State IDLE, done_o=0, busy_o=0, result_o=0, rd_addr_o=0, counter=0, internal accumulators=0. Reset wins over every other input, including mid-operation.
- Accept rule: start_i is sampled in IDLE when done_o=0 and flush_i=0.
  - start_i is ignored in the cycle done_o=1, because the same instruction is still in EX.
  - On accept, latch op, rd_addr_i, |op1|, |op2| and the result-sign flags.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: sign-agnostic (low word).
  - DIV/REM: signed. Quotient is negative when signs differ. Remainder takes the sign of the dividend.
- States:
  - IDLE: on accept, go to CALC with counter=0. Special divide cases go straight to FIX.
  - CALC: one iteration per cycle. Exits to FIX after XLEN iterations (counter reaches XLEN).
    - Multiply: 2*XLEN-bit product; add multiplicand if the multiplier LSB is set, then shift right.
    - Divide: restoring; shift the remainder left, bring in the next dividend MSB, trial-subtract the divisor, set the quotient bit when non-negative.
  - FIX: apply two's-complement negation per the sign flags. Select low/high product word, or quotient/remainder. Go to DONE.
  - DONE: result_o <= value and done_o <= 1 on entry. Return to IDLE on the next edge; done_o drops to 0.
- Special divide cases (skip CALC; latency 3 edges from accept to done_o high):
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = op1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Latency, normal op: accept at edge E0; CALC covers E1..E32; FIX at E33; done_o high during the cycle after E34. Total is XLEN+3 edges.
- stall_o = (start_i & state==IDLE & ~done_o) | (state != IDLE & state != DONE-exit).
  - stall_o is 0 in the cycle done_o=1, so EX advances and captures result_o.
  - stall_o is 0 whenever flush_i=1.
- Flush in any non-IDLE state: return to IDLE at the next edge. No done_o pulse; result_o and rd_addr_o keep their prior values.
- Flush and done_o in the same cycle: done_o still completes (it is already registered); the consumer gates the write with its own flush.
- Back-to-back: a new start_i is accepted in the cycle after done_o drops.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done_o exactly 35 edges after accept; result_o=0xFFFFFFEB; stall_o high for 34 cycles, then low in the done cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each done_o appears 3 edges after accept.
- Assert flush_i at CALC iteration 10 -> IDLE next edge; no done_o; stall_o=0; result_o unchanged. A subsequent MULHU completes normally.
- Assert resetn_i low mid-CALC (asynchronous, between edges) -> all outputs 0 immediately. start_i held high through the done cycle -> no second operation launched.
